// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// Holds the state and owner encodings plus the address range check.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_cmd_t;

  // Widened to 65 bits so addresses near 2^64 cannot wrap into range.
  function automatic logic addr_ok(
    input logic [63:0] addr,
    input int unsigned bytes
  );
    logic [64:0] last;
    last = {1'b0, addr} + 65'd8;
    return last <= 65'(bytes);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter for the memory port.
// Flags expiry once the count reaches TIMEOUT-1.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wd <= 8'd0;
    end else if (en) begin
      wd <= wd + 8'd1;
    end
  end

  assign expired = (wd == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one req/ack memory port.
// Out-of-range requests and stalled transactions complete with err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_valid,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic        m_ack,
  input  logic [63:0] m_rdata
);

  arb_state_t state, state_n;
  owner_t     owner, owner_n;
  owner_t     last, last_n;

  logic        m_req_n;
  logic        m_we_n;
  logic [63:0] m_addr_n;
  logic [63:0] m_wdata_n;

  logic        f_valid_n, d_valid_n;
  logic [63:0] f_rdata_n, d_rdata_n;
  logic        f_err_n, d_err_n;

  logic        gnt_f, gnt_d;
  owner_t      gnt_own;
  mem_cmd_t    gnt_cmd;

  logic        fin;
  owner_t      fin_own;
  logic [63:0] fin_rdata;
  logic        fin_err;

  logic        wd_clr, wd_en, wd_exp;

  assign wd_clr = (state != ARB_BUSY);
  assign wd_en  = (state == ARB_BUSY) && !m_ack;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_exp)
  );

  // On a tie the port that did not win last time is served.
  assign gnt_d = d_req && (!f_req || last == OWN_F);
  assign gnt_f = f_req && !gnt_d;

  always_comb begin
    gnt_own = OWN_F;
    gnt_cmd = '{we: 1'b0, addr: f_addr, wdata: 64'd0};
    if (gnt_d) begin
      gnt_own = OWN_D;
      gnt_cmd = '{we: d_we, addr: d_addr, wdata: d_wdata};
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    m_req_n   = m_req;
    m_we_n    = m_we;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    fin       = 1'b0;
    fin_own   = owner;
    fin_rdata = 64'd0;
    fin_err   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (gnt_d || gnt_f) begin
          owner_n   = gnt_own;
          last_n    = gnt_own;
          m_we_n    = gnt_cmd.we;
          m_addr_n  = gnt_cmd.addr;
          m_wdata_n = gnt_cmd.wdata;
          if (addr_ok(gnt_cmd.addr, MEM_BYTES)) begin
            state_n = ARB_BUSY;
            m_req_n = 1'b1;
          end else begin
            state_n = ARB_RESP;
            fin     = 1'b1;
            fin_own = gnt_own;
            fin_err = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        unique case (1'b1)
          m_ack: begin
            state_n   = ARB_RESP;
            m_req_n   = 1'b0;
            fin       = 1'b1;
            fin_rdata = m_we ? 64'd0 : m_rdata;
          end
          wd_exp: begin
            state_n = ARB_RESP;
            m_req_n = 1'b0;
            fin     = 1'b1;
            fin_err = 1'b1;
          end
          default: ;
        endcase
      end
      ARB_RESP: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  always_comb begin
    f_valid_n = fin && (fin_own == OWN_F);
    d_valid_n = fin && (fin_own == OWN_D);
    f_rdata_n = f_valid_n ? fin_rdata : 64'd0;
    d_rdata_n = d_valid_n ? fin_rdata : 64'd0;
    f_err_n   = f_valid_n && fin_err;
    d_err_n   = d_valid_n && fin_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      owner   <= OWN_F;
      last    <= OWN_F;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 64'd0;
      m_wdata <= 64'd0;
      f_valid <= 1'b0;
      f_rdata <= 64'd0;
      f_err   <= 1'b0;
      d_valid <= 1'b0;
      d_rdata <= 64'd0;
      d_err   <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      m_req   <= m_req_n;
      m_we    <= m_we_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
      f_valid <= f_valid_n;
      f_rdata <= f_rdata_n;
      f_err   <= f_err_n;
      d_valid <= d_valid_n;
      d_rdata <= d_rdata_n;
      d_err   <= d_err_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks for mem_port_arbiter.
// A small responder acks memory requests after a set delay.
module tb_mem_port_arbiter;

  localparam int unsigned MB = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = 64'd0;
  logic        f_valid;
  logic [63:0] f_rdata;
  logic        f_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = 64'd0;
  logic [63:0] d_wdata = 64'd0;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [63:0] m_rdata = 64'd0;

  mem_port_arbiter #(
    .MEM_BYTES(MB),
    .TIMEOUT  (255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .f_addr (f_addr),
    .f_valid(f_valid),
    .f_rdata(f_rdata),
    .f_err  (f_err),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_valid(d_valid),
    .d_rdata(d_rdata),
    .d_err  (d_err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ack after ack_lat cycles of m_req (-1 = never).
  int          ack_lat = 0;
  int          rcnt = 0;
  logic        late_ack = 1'b0;
  logic [63:0] rdata_val = 64'd0;

  always @(negedge clk) begin
    #1;
    m_rdata = rdata_val;
    m_ack = late_ack ||
            (m_req && ack_lat >= 0 && rcnt == ack_lat);
    rcnt = m_req ? rcnt + 1 : 0;
  end

  int mreq_cnt = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    if (m_req) mreq_cnt++;
    if (f_valid && d_valid) both_cnt++;
  end

  logic [63:0] seen_addr;
  logic        seen_we;
  int          cyc;

  task automatic wait_done(input int limit, output int c);
    c = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (m_req) begin
        seen_addr = m_addr;
        seen_we   = m_we;
      end
      if (f_valid || d_valid) begin
        c = i;
        break;
      end
    end
  endtask

  initial begin
    seen_addr = 64'd0;
    seen_we   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mreq", 64'(m_req), 64'd0);
    chk("rst_valids", 64'({f_valid, d_valid}), 64'd0);
    chk("rst_rdata", f_rdata | d_rdata, 64'd0);
    chk("rst_errs", 64'({f_err, d_err}), 64'd0);

    // Single data read, ack at cycle 3
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    ack_lat = 2; rdata_val = 64'hDEADBEEF; mreq_cnt = 0;
    wait_done(20, cyc);
    d_req = 1'b0;
    chk("rd_lat", 64'(cyc), 64'd4);
    chk("rd_dvalid", 64'({f_valid, d_valid}), 64'd1);
    chk("rd_rdata", d_rdata, 64'hDEADBEEF);
    chk("rd_err", 64'(d_err), 64'd0);
    chk("rd_addr", seen_addr, 64'h100);
    chk("rd_mreq_cyc", 64'(mreq_cnt), 64'd3);
    @(negedge clk);
    chk("rd_pulse", 64'(d_valid), 64'd0);

    // Continuous tie from reset: D, F, D
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f_req = 1'b1; f_addr = 64'h200;
    d_req = 1'b1; d_addr = 64'h300;
    ack_lat = 0; rdata_val = 64'h1111;
    wait_done(20, cyc);
    chk("tie1_lat", 64'(cyc), 64'd2);
    chk("tie1_own", 64'({f_valid, d_valid}), 64'b01);
    chk("tie1_addr", seen_addr, 64'h300);
    wait_done(20, cyc);
    chk("tie2_lat", 64'(cyc), 64'd3);
    chk("tie2_own", 64'({f_valid, d_valid}), 64'b10);
    chk("tie2_addr", seen_addr, 64'h200);
    chk("tie2_rdata", f_rdata, 64'h1111);
    wait_done(20, cyc);
    chk("tie3_lat", 64'(cyc), 64'd3);
    chk("tie3_own", 64'({f_valid, d_valid}), 64'b01);
    chk("tie3_addr", seen_addr, 64'h300);
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Range error: write at MEM_BYTES-4
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'(MB - 4);
    d_wdata = 64'h55; mreq_cnt = 0;
    wait_done(20, cyc);
    d_req = 1'b0;
    chk("rng_lat", 64'(cyc), 64'd1);
    chk("rng_err", 64'(d_err), 64'd1);
    chk("rng_rdata", d_rdata, 64'd0);
    chk("rng_mreq", 64'(mreq_cnt), 64'd0);
    @(negedge clk);

    // Last legal address, write, ack immediately
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'(MB - 8);
    d_wdata = 64'hCAFE; rdata_val = 64'h7777;
    ack_lat = 0; mreq_cnt = 0;
    wait_done(20, cyc);
    d_req = 1'b0; d_we = 1'b0;
    chk("wr_lat", 64'(cyc), 64'd2);
    chk("wr_err", 64'(d_err), 64'd0);
    chk("wr_rdata", d_rdata, 64'd0);
    chk("wr_we", 64'(seen_we), 64'd1);
    chk("wr_wdata", m_wdata, 64'hCAFE);
    @(negedge clk);

    // Near-2^64 address must not wrap into range
    d_req = 1'b1; d_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    mreq_cnt = 0;
    wait_done(20, cyc);
    d_req = 1'b0;
    chk("wrap_lat", 64'(cyc), 64'd1);
    chk("wrap_err", 64'(d_err), 64'd1);
    chk("wrap_mreq", 64'(mreq_cnt), 64'd0);
    @(negedge clk);

    // Fetch range error lands on the fetch port
    f_req = 1'b1; f_addr = 64'(MB - 7);
    wait_done(20, cyc);
    f_req = 1'b0;
    chk("frng_own", 64'({f_valid, d_valid}), 64'b10);
    chk("frng_err", 64'(f_err), 64'd1);
    @(negedge clk);

    // Timeout, then a late ack that must be ignored
    d_req = 1'b1; d_addr = 64'h40;
    ack_lat = -1; mreq_cnt = 0;
    wait_done(400, cyc);
    d_req = 1'b0;
    chk("to_lat", 64'(cyc), 64'd256);
    chk("to_err", 64'(d_err), 64'd1);
    chk("to_rdata", d_rdata, 64'd0);
    chk("to_mreq_cyc", 64'(mreq_cnt), 64'd255);
    late_ack = 1'b1;
    wait_done(3, cyc);
    late_ack = 1'b0;
    chk("late_ack", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("late_mreq", 64'(m_req), 64'd0);

    // Normal fetch after the abort
    f_req = 1'b1; f_addr = 64'h80;
    ack_lat = 1; rdata_val = 64'h0123_4567_89AB_CDEF;
    wait_done(20, cyc);
    f_req = 1'b0;
    chk("f_lat", 64'(cyc), 64'd3);
    chk("f_rdata", f_rdata, 64'h0123_4567_89AB_CDEF);
    chk("f_err", 64'(f_err), 64'd0);
    chk("f_we", 64'(seen_we), 64'd0);
    @(negedge clk);

    // Reset mid-BUSY, then the first tie goes to data
    d_req = 1'b1; d_addr = 64'h88; ack_lat = -1;
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'(m_req), 64'd1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_mreq", 64'(m_req), 64'd0);
    chk("mid_rst_valid", 64'({f_valid, d_valid}), 64'd0);
    chk("mid_rst_out", f_rdata | d_rdata, 64'd0);
    rst = 1'b0;
    f_req = 1'b1; f_addr = 64'h500;
    d_req = 1'b1; d_addr = 64'h600;
    ack_lat = 0;
    wait_done(20, cyc);
    f_req = 1'b0; d_req = 1'b0;
    chk("post_rst_lat", 64'(cyc), 64'd2);
    chk("post_rst_own", 64'({f_valid, d_valid}), 64'b01);
    chk("post_rst_addr", seen_addr, 64'h600);
    repeat (2) @(negedge clk);

    chk("never_both", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
